lcd_read_object: RTL and testbench

//  Read-side companion to the LCD character writer: drives the HD44780-style
//  bus with lcd_rw=1 to fetch the busy flag/address counter (status read) or
//  one DDRAM character at a given address (data read).

---
 rtl/lcd_read_object.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_read_object.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_read_object.sv
// lcd_read_object: read-side HD44780 bus sequencer. Performs either a status
// read (busy flag + address counter) or a DDRAM data read at a given address.
// A data read sets the DDRAM address, polls the busy flag until it clears and
// then fetches the character. The block owns the bus only between request
// accept and the response pulse.
module lcd_read_object #(
  parameter int EN_CYC   = 4,
  parameter int GAP_CYC  = 4,
  parameter int POLL_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mode,
  input  logic [6:0] req_addr,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  // One bus access: a setup cycle, EN_CYC strobe cycles, GAP_CYC recovery cycles.
  localparam int ACC_LEN = 1 + EN_CYC + GAP_CYC;
  localparam int CW      = $clog2(ACC_LEN);

  localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYC);
  localparam logic [CW-1:0] ACC_LAST = CW'(ACC_LEN - 1);
  localparam logic [7:0]    POLL_LIM = 8'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAT,
    S_ADDR,
    S_POLL,
    S_DRD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    poll_cnt_q, poll_cnt_d;
  logic [7:0]    sample_q, sample_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic          rw_q, rw_d;
  logic          oe_q, oe_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          req_ready_q, req_ready_d;

  logic          finish_now;
  logic [7:0]    finish_data;
  logic          finish_tmo;

  // Next-state and next-output computation; every bus pin is registered so the
  // strobe timing is glitch free and rs/rw/oe only move while en is low.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    poll_cnt_d    = poll_cnt_q;
    sample_d      = sample_q;
    en_d          = 1'b0;
    rs_d          = rs_q;
    rw_d          = rw_q;
    oe_d          = oe_q;
    data_out_d    = data_out_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    req_ready_d   = 1'b0;
    finish_now    = 1'b0;
    finish_data   = 8'h00;
    finish_tmo    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          cnt_d       = '0;
          rs_d        = 1'b0;
          if (req_mode) begin
            state_d    = S_ADDR;
            rw_d       = 1'b0;
            oe_d       = 1'b1;
            data_out_d = 8'h80 | {1'b0, req_addr};
          end else begin
            state_d = S_STAT;
            rw_d    = 1'b1;
            oe_d    = 1'b0;
          end
        end
      end

      S_STAT, S_ADDR, S_POLL, S_DRD: begin
        if (cnt_q == EN_LAST) begin
          sample_d = lcd_data_in;
          if (state_q == S_ADDR) begin
            oe_d = 1'b0;
          end
        end
        if (cnt_q != ACC_LAST) begin
          cnt_d = cnt_q + CW'(1);
          en_d  = (cnt_d <= EN_LAST);
        end else begin
          cnt_d = '0;
          case (state_q)
            S_STAT: begin
              finish_now  = 1'b1;
              finish_data = sample_q;
            end
            S_ADDR: begin
              state_d    = S_POLL;
              poll_cnt_d = 8'h00;
              rs_d       = 1'b0;
              rw_d       = 1'b1;
              oe_d       = 1'b0;
            end
            S_POLL: begin
              if (!sample_q[7]) begin
                state_d = S_DRD;
                rs_d    = 1'b1;
                rw_d    = 1'b1;
                oe_d    = 1'b0;
              end else if (poll_cnt_q < POLL_LIM) begin
                poll_cnt_d = poll_cnt_q + 8'd1;
              end else begin
                finish_now  = 1'b1;
                finish_data = 8'h00;
                finish_tmo  = 1'b1;
              end
            end
            default: begin
              finish_now  = 1'b1;
              finish_data = sample_q;
            end
          endcase
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rs_d        = 1'b0;
        rw_d        = 1'b1;
        oe_d        = 1'b0;
      end
    endcase

    if (finish_now) begin
      state_d       = S_DONE;
      rsp_valid_d   = 1'b1;
      rsp_data_d    = finish_data;
      rsp_timeout_d = finish_tmo;
      rs_d          = 1'b0;
      rw_d          = 1'b1;
      oe_d          = 1'b0;
    end
  end

  // State and output registers; reset parks the bus in idle read mode at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      poll_cnt_q    <= 8'h00;
      sample_q      <= 8'h00;
      en_q          <= 1'b0;
      rs_q          <= 1'b0;
      rw_q          <= 1'b1;
      oe_q          <= 1'b0;
      data_out_q    <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_timeout_q <= 1'b0;
      req_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      poll_cnt_q    <= poll_cnt_d;
      sample_q      <= sample_d;
      en_q          <= en_d;
      rs_q          <= rs_d;
      rw_q          <= rw_d;
      oe_q          <= oe_d;
      data_out_q    <= data_out_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      req_ready_q   <= req_ready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign lcd_data_out = data_out_q;
  assign lcd_data_oe  = oe_q;
  assign lcd_rs       = rs_q;
  assign lcd_rw       = rw_q;
  assign lcd_en       = en_q;

endmodule

// File: tb/tb_lcd_read_object.sv
// tb_lcd_read_object: drives lcd_read_object against a small HD44780 read model
// and checks responses, latencies, strobe sequences and bus protocol rules.
module tb_lcd_read_object;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_mode;
  logic [6:0] req_addr;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [7:0] lcd_data_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  lcd_read_object #(.EN_CYC(4), .GAP_CYC(4), .POLL_MAX(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .lcd_data_in  (lcd_data_in),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en)
  );

  typedef struct {
    logic [7:0] data;
    logic       tmo;
    int         rsp_cyc;
  } exp_t;

  exp_t sb[$];

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;

  // LCD model state: DDRAM and busy configuration belong to the stimulus,
  // address counter and poll index belong to the bus monitor.
  logic [7:0] ddram [0:127];
  logic [6:0] stat_low;
  int         busy_cfg;
  logic [6:0] ac;
  int         poll_idx;

  // Monitor counters
  int         addr_strobes = 0;
  int         poll_strobes = 0;
  int         data_strobes = 0;
  int         rsp_count    = 0;
  int         viol         = 0;
  logic [7:0] addr_seen    = 8'h00;
  logic       prev_en = 1'b0, prev_rs = 1'b0, prev_rw = 1'b1, prev_oe = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Read data returned by the panel: busy flag/status or addressed character
  always_comb begin
    if (lcd_rs) lcd_data_in = ddram[ac];
    else        lcd_data_in = {(poll_idx < busy_cfg), stat_low};
  end

  // Bus monitor: classifies strobes, updates the model and counts rule breaks
  initial begin
    ac       = 7'h00;
    poll_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!prev_en && lcd_en) begin
          if (!lcd_rs && !lcd_rw) begin
            addr_strobes++;
            addr_seen = lcd_data_out;
            ac        = lcd_data_out[6:0];
            poll_idx  = 0;
            if (lcd_data_oe !== 1'b1) viol++;
          end else if (!lcd_rs && lcd_rw) begin
            poll_strobes++;
          end else if (lcd_rs && lcd_rw) begin
            data_strobes++;
          end
        end
        if (prev_en && !lcd_en && !prev_rs && prev_rw) poll_idx++;
        if (prev_en && lcd_en &&
            (lcd_rs !== prev_rs || lcd_rw !== prev_rw || lcd_data_oe !== prev_oe)) viol++;
        if (lcd_data_oe && lcd_rw) viol++;
        if (rsp_valid === 1'b1) rsp_count++;
      end
      prev_en = lcd_en;
      prev_rs = lcd_rs;
      prev_rw = lcd_rw;
      prev_oe = lcd_data_oe;
    end
  end

  // Watchdog so the run always terminates
  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation still running after 20000 cycles, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic issue_req(input logic mode, input logic [6:0] addr,
                           input logic [7:0] edata, input logic etmo, input int elat);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = mode;
    req_addr  = addr;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      compared++; failed++;
      $display("[TB] FAIL accept_wait: req_ready=%b required 1", req_ready);
    end else begin
      e.data    = edata;
      e.tmo     = etmo;
      e.rsp_cyc = cyc + elat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic take_rsp(input int budget, output bit ok, output exp_t e,
                          output logic [7:0] d, output logic t, output int at);
    bit got;
    got = 1'b0; d = 8'h00; t = 1'b0; at = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1; d = rsp_data; t = rsp_timeout; at = cyc;
      end
    end
    ok = got && (sb.size() > 0);
    if (ok) e = sb.pop_front();
    else    e = '{default: '0};
    if (!got) begin
      compared++; failed++;
      $display("[TB] FAIL rsp_wait: no rsp_valid within %0d cycles, required one", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_addr = 7'h00;
    repeat (3) @(negedge clk);
    compared++; if (lcd_en !== 1'b0)       begin failed++; $display("[TB] FAIL rst_en: got %b want 0", lcd_en); end
    compared++; if (lcd_rw !== 1'b1)       begin failed++; $display("[TB] FAIL rst_rw: got %b want 1", lcd_rw); end
    compared++; if (lcd_rs !== 1'b0)       begin failed++; $display("[TB] FAIL rst_rs: got %b want 0", lcd_rs); end
    compared++; if (lcd_data_oe !== 1'b0)  begin failed++; $display("[TB] FAIL rst_oe: got %b want 0", lcd_data_oe); end
    compared++; if (lcd_data_out !== 8'h00) begin failed++; $display("[TB] FAIL rst_dout: got %h want 00", lcd_data_out); end
    compared++; if (rsp_valid !== 1'b0)    begin failed++; $display("[TB] FAIL rst_rspv: got %b want 0", rsp_valid); end
    compared++; if (rsp_data !== 8'h00)    begin failed++; $display("[TB] FAIL rst_rspd: got %h want 00", rsp_data); end
    compared++; if (rsp_timeout !== 1'b0)  begin failed++; $display("[TB] FAIL rst_tmo: got %b want 0", rsp_timeout); end
    rst = 1'b0;
    @(negedge clk);
    compared++; if (req_ready !== 1'b1)    begin failed++; $display("[TB] FAIL rst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_status();
    bit ok; exp_t e; logic [7:0] d; logic t; int at;
    stat_low = 7'h05; busy_cfg = 0;
    issue_req(1'b0, 7'h00, 8'h05, 1'b0, 10);
    take_rsp(60, ok, e, d, t, at);
    if (ok) begin
      compared++; if (d !== e.data)      begin failed++; $display("[TB] FAIL stat_data: got %h want %h", d, e.data); end
      compared++; if (t !== e.tmo)       begin failed++; $display("[TB] FAIL stat_tmo: got %b want %b", t, e.tmo); end
      compared++; if (at !== e.rsp_cyc)  begin failed++; $display("[TB] FAIL stat_latency: got cycle %0d want %0d", at, e.rsp_cyc); end
      @(negedge clk);
      compared++; if (rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL stat_pulse: rsp_valid=%b one cycle later, want 0", rsp_valid); end
    end
  endtask

  task automatic test_data_read();
    bit ok; exp_t e; logic [7:0] d; logic t; int at; int p0, d0;
    busy_cfg = 0;
    p0 = poll_strobes; d0 = data_strobes;
    issue_req(1'b1, 7'h4F, 8'h03, 1'b0, 28);
    take_rsp(80, ok, e, d, t, at);
    if (ok) begin
      compared++; if (d !== e.data)     begin failed++; $display("[TB] FAIL drd_data: got %h want %h", d, e.data); end
      compared++; if (t !== e.tmo)      begin failed++; $display("[TB] FAIL drd_tmo: got %b want %b", t, e.tmo); end
      compared++; if (at !== e.rsp_cyc) begin failed++; $display("[TB] FAIL drd_latency: got cycle %0d want %0d", at, e.rsp_cyc); end
      compared++; if (addr_seen !== 8'hCF) begin failed++; $display("[TB] FAIL drd_addr_cmd: got %h want CF", addr_seen); end
      compared++; if (poll_strobes - p0 !== 1) begin failed++; $display("[TB] FAIL drd_polls: got %0d want 1", poll_strobes - p0); end
      compared++; if (data_strobes - d0 !== 1) begin failed++; $display("[TB] FAIL drd_rs_strobes: got %0d want 1", data_strobes - d0); end
    end
  endtask

  task automatic test_busy_wait();
    bit ok; exp_t e; logic [7:0] d; logic t; int at; int p0, d0;
    busy_cfg = 3;
    p0 = poll_strobes; d0 = data_strobes;
    issue_req(1'b1, 7'h05, 8'h42, 1'b0, 28 + 3 * 9);
    take_rsp(150, ok, e, d, t, at);
    if (ok) begin
      compared++; if (d !== e.data)     begin failed++; $display("[TB] FAIL busy_data: got %h want %h", d, e.data); end
      compared++; if (t !== e.tmo)      begin failed++; $display("[TB] FAIL busy_tmo: got %b want %b", t, e.tmo); end
      compared++; if (at !== e.rsp_cyc) begin failed++; $display("[TB] FAIL busy_latency: got cycle %0d want %0d", at, e.rsp_cyc); end
      compared++; if (poll_strobes - p0 !== 4) begin failed++; $display("[TB] FAIL busy_polls: got %0d want 4", poll_strobes - p0); end
      compared++; if (data_strobes - d0 !== 1) begin failed++; $display("[TB] FAIL busy_rs_strobes: got %0d want 1", data_strobes - d0); end
    end
  endtask

  task automatic test_timeout();
    bit ok; exp_t e; logic [7:0] d; logic t; int at; int p0, d0;
    busy_cfg = 1000;
    p0 = poll_strobes; d0 = data_strobes;
    issue_req(1'b1, 7'h4F, 8'h00, 1'b1, 1 + 9 * 5);
    take_rsp(150, ok, e, d, t, at);
    if (ok) begin
      compared++; if (d !== e.data)     begin failed++; $display("[TB] FAIL tmo_data: got %h want %h", d, e.data); end
      compared++; if (t !== e.tmo)      begin failed++; $display("[TB] FAIL tmo_flag: got %b want %b", t, e.tmo); end
      compared++; if (at !== e.rsp_cyc) begin failed++; $display("[TB] FAIL tmo_latency: got cycle %0d want %0d", at, e.rsp_cyc); end
      compared++; if (poll_strobes - p0 !== 4) begin failed++; $display("[TB] FAIL tmo_polls: got %0d want 4", poll_strobes - p0); end
      compared++; if (data_strobes - d0 !== 0) begin failed++; $display("[TB] FAIL tmo_rs_strobes: got %0d want 0", data_strobes - d0); end
    end
    busy_cfg = 0;
  endtask

  task automatic test_reset_mid_access();
    bit ok; exp_t e; logic [7:0] d; logic t; int at; int r0; bit hit;
    busy_cfg = 10;
    issue_req(1'b1, 7'h10, 8'h00, 1'b0, 0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (lcd_en === 1'b1 && lcd_rw === 1'b1 && lcd_rs === 1'b0) hit = 1'b1;
    end
    compared++;
    if (!hit) begin
      failed++; $display("[TB] FAIL mid_poll_wait: no poll strobe seen, required one");
    end
    rst = 1'b1;
    #1;
    compared++; if (lcd_en !== 1'b0) begin failed++; $display("[TB] FAIL mid_en_drop: got %b want 0", lcd_en); end
    sb.delete();
    r0 = rsp_count;
    busy_cfg = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++; if (req_ready !== 1'b1) begin failed++; $display("[TB] FAIL mid_ready: got %b want 1", req_ready); end
    repeat (20) @(negedge clk);
    compared++; if (rsp_count !== r0) begin failed++; $display("[TB] FAIL mid_no_rsp: got %0d responses want 0", rsp_count - r0); end
    issue_req(1'b1, 7'h4F, 8'h03, 1'b0, 28);
    take_rsp(80, ok, e, d, t, at);
    if (ok) begin
      compared++; if (d !== e.data)     begin failed++; $display("[TB] FAIL mid_next_data: got %h want %h", d, e.data); end
      compared++; if (at !== e.rsp_cyc) begin failed++; $display("[TB] FAIL mid_next_latency: got cycle %0d want %0d", at, e.rsp_cyc); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int acc, rsp;
    stat_low = 7'h2A; busy_cfg = 0;
    acc = 0; rsp = 0;
    @(negedge clk);
    req_mode = 1'b0; req_addr = 7'h00; req_valid = 1'b1;
    for (int i = 0; i < 73; i++) begin
      if (i == 33) req_valid = 1'b0;
      if (req_valid && req_ready === 1'b1) begin
        acc++;
        e.data = 8'h2A; e.tmo = 1'b0; e.rsp_cyc = cyc + 10;
        sb.push_back(e);
      end
      if (rsp_valid === 1'b1) begin
        rsp++;
        compared++;
        if (sb.size() == 0) begin
          failed++; $display("[TB] FAIL b2b_extra_rsp: response with empty scoreboard, want none");
        end else begin
          e = sb.pop_front();
          if (rsp_data !== e.data || cyc !== e.rsp_cyc) begin
            failed++;
            $display("[TB] FAIL b2b_rsp: got data %h at cycle %0d want %h at %0d", rsp_data, cyc, e.data, e.rsp_cyc);
          end
        end
      end
      @(negedge clk);
    end
    compared++; if (acc !== 3) begin failed++; $display("[TB] FAIL b2b_accepts: got %0d want 3", acc); end
    compared++; if (rsp !== 3) begin failed++; $display("[TB] FAIL b2b_rsps: got %0d want 3", rsp); end
    compared++; if (sb.size() !== 0) begin failed++; $display("[TB] FAIL b2b_pending: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_protocol();
    compared++;
    if (viol !== 0) begin
      failed++; $display("[TB] FAIL protocol: got %0d bus rule violations want 0", viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ddram[i] = 8'(i) ^ 8'h5A;
    ddram[7'h4F] = 8'h03;
    ddram[7'h05] = 8'h42;
    stat_low = 7'h00;
    busy_cfg = 0;
    test_reset();
    test_status();
    test_data_read();
    test_busy_wait();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
